sensor_access_scheduler: RTL and testbench
==========================================

// Module: sensor_access_scheduler
// PURPOSE
//  Owns the single DHT11 interface_sensor instance and shares it between two requester classes.
//  - One-shot reads from controller_unit.
//  - Background round-robin refresh of up to 32 addresses with continuous monitoring enabled.
//  Enforces the DHT11 minimum inter-read gap, a read timeout and a checksum check.
//  Results go back to controller_unit through one valid/ready response port.
// PARAMETERS
//  NUM_SENSORS     32           addressable sensors; sets the width of cont_mask
//  ADDR_W          5            sensor address width
//  GAP_CYCLES      100_000_000  idle cycles required between two sensor_start pulses (2 s at 50 MHz)
//  TIMEOUT_CYCLES  2_500_000    maximum cycles from sensor_start to sensor_done (50 ms)
// PORTS
//  clock_50Mhz  in   1       system clock, all logic on the rising edge
//  reset_n      in   1       synchronous reset, active-low
//  req_valid    in   1       one-shot read request
//  req_addr     in   ADDR_W  address for the one-shot read
//  req_ready    out  1       request accepted on the cycle where req_valid && req_ready
//  cont_set     in   1       pulse: enable continuous monitoring of cont_addr
//  cont_clr     in   1       pulse: disable continuous monitoring of cont_addr
//  cont_addr    in   ADDR_W  target address for cont_set / cont_clr
//  cont_mask    out  NUM_SENSORS  current continuous-enable bits
//  sensor_start out  1       one-cycle pulse to interface_sensor
//  sensor_addr  out  ADDR_W  address of the transaction in flight
//  sensor_done  in   1       one-cycle pulse from interface_sensor: data_sensor is valid
//  data_sensor  in   40      {hum_int, hum_dec, temp_int, temp_dec, checksum}
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       response consumed on the cycle where rsp_valid && rsp_ready
//  rsp_addr     out  ADDR_W  address the response belongs to
//  rsp_data     out  40      captured sensor bytes; all zero on timeout
//  rsp_err      out  2       00 ok, 01 checksum fail, 10 timeout
//  rsp_cont     out  1       1 = response comes from the continuous scan
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): all outputs 0; req_ready=0; FSM=IDLE; gap counter loaded with 0 (first read may start at once); rr_ptr=0.
//  FSM: IDLE -> START -> WAIT -> RESP -> HOLD -> IDLE.
//  - IDLE: req_ready=1 while gap is expired.
//    - req_valid seen: latch the address, set rsp_cont=0, go to START.
//    - else if cont_mask!=0: pick the first set bit at or after rr_ptr (wrapping), set rsp_cont=0->1, go to START.
//    - One-shot requests always win over continuous refresh.
//  - START: sensor_start=1 for exactly one cycle, timeout counter cleared, go to WAIT. req_ready=0 from START through HOLD.
//  - WAIT, sensor_done seen: capture data_sensor.
//    - Checksum = (b4+b3+b2+b1) mod 256, compared with b0; mismatch gives rsp_err=01.
//    - Go to RESP.
//  - WAIT, TIMEOUT_CYCLES reached with no sensor_done: rsp_err=10, rsp_data=0, go to RESP.
//    - A late sensor_done arriving after this point is ignored.
//  - RESP: rsp_valid held until rsp_ready. All rsp_* fields stay stable while rsp_valid=1.
//    - On the handshake: load the gap counter with GAP_CYCLES; if rsp_cont, rr_ptr = served address + 1 (wrapping NUM_SENSORS-1 -> 0).
//  - HOLD: count down to 0, then go to IDLE. The gap starts at the response handshake, never at sensor_done.
//  - Latency: req_valid accepted in IDLE -> sensor_start on the next cycle.
//  cont_mask updates in any state, taking effect on the next edge.
//  - cont_set and cont_clr on the same cycle and same address: clr wins.
//  - Clearing the address currently in flight does not abort it; its response is still delivered with rsp_cont=1.
//  - cont_addr >= NUM_SENSORS: ignored.
//  reset_n low mid-transaction returns to IDLE immediately. No response is produced for the aborted read.
// STRUCTURE
//  Shared package sensor_pkg:
//  - FSM state encodings;
//  - RSP_OK=2'b00, RSP_CKSUM=2'b01, RSP_TIMEOUT=2'b10;
//  - DHT11 byte field offsets.
//  Sub-module rr_picker: combinational next-set-bit search over cont_mask starting at rr_ptr, with a found flag.
//  All counters, the FSM and cont_mask live in the top level. Test builds use GAP_CYCLES=20 and TIMEOUT_CYCLES=50.
// TESTING
//  1. One-shot addr 3, sensor_done with 0x2A_00_19_00_43: exactly one sensor_start, then rsp_addr=3, rsp_err=00, rsp_cont=0.
//  2. Checksum fail: data 0x2A_00_19_00_44 -> rsp_err=01 and rsp_data echoes the input.
//  3. Timeout: no sensor_done for 50 cycles -> rsp_err=10, rsp_data=0; a sensor_done 5 cycles later is ignored.
//  4. Round-robin: cont_set on 2, 5, 31 -> addresses served 2, 5, 31, 2; every pair of sensor_start pulses is >= 20 cycles apart counted from the rsp handshake.
//  5. Priority: req_valid(addr 7) raised during HOLD with cont_mask!=0 -> addr 7 is served before any continuous read.
//  6. Reset mid-WAIT, then cont_set+cont_clr on addr 4 in the same cycle: all outputs 0, and cont_mask[4] stays 0.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the DHT11 access scheduler: FSM states, response codes,
// byte layout of the 40-bit sensor word and the checksum rule.
package sensor_pkg;

    localparam int unsigned DataW = 40;

    localparam int unsigned HumIntLsb  = 32;
    localparam int unsigned HumDecLsb  = 24;
    localparam int unsigned TempIntLsb = 16;
    localparam int unsigned TempDecLsb = 8;
    localparam int unsigned CksumLsb   = 0;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_CKSUM   = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StResp,
        StHold
    } sched_state_e;

    function automatic logic cksum_ok(input logic [DataW-1:0] d);
        logic [7:0] sum;
        sum = d[HumIntLsb +: 8] + d[HumDecLsb +: 8] + d[TempIntLsb +: 8] + d[TempDecLsb +: 8];
        return sum == d[CksumLsb +: 8];
    endfunction

endpackage

// File: rtl/sensor_access_scheduler_if.sv
// Request, continuous-enable, sensor-side and response signals of the access scheduler.
// master = controller/sensor side, slave = scheduler.
interface sensor_access_scheduler_if #(
    parameter int unsigned NUM_SENSORS = 32,
    parameter int unsigned ADDR_W      = 5
) ();
    import sensor_pkg::*;

    logic                   req_valid;
    logic [ADDR_W-1:0]      req_addr;
    logic                   req_ready;

    logic                   cont_set;
    logic                   cont_clr;
    logic [ADDR_W-1:0]      cont_addr;
    logic [NUM_SENSORS-1:0] cont_mask;

    logic                   sensor_start;
    logic [ADDR_W-1:0]      sensor_addr;
    logic                   sensor_done;
    logic [DataW-1:0]       data_sensor;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ADDR_W-1:0]      rsp_addr;
    logic [DataW-1:0]       rsp_data;
    logic [1:0]             rsp_err;
    logic                   rsp_cont;

    modport master (
        output req_valid, req_addr, cont_set, cont_clr, cont_addr, sensor_done, data_sensor,
               rsp_ready,
        input  req_ready, cont_mask, sensor_start, sensor_addr, rsp_valid, rsp_addr, rsp_data,
               rsp_err, rsp_cont
    );

    modport slave (
        input  req_valid, req_addr, cont_set, cont_clr, cont_addr, sensor_done, data_sensor,
               rsp_ready,
        output req_ready, cont_mask, sensor_start, sensor_addr, rsp_valid, rsp_addr, rsp_data,
               rsp_err, rsp_cont
    );

endinterface

// File: rtl/sensor_access_scheduler_rr_picker.sv
// Combinational round-robin search: first set bit of mask_i at or after ptr_i, wrapping.
module rr_picker #(
    parameter int unsigned NUM_SENSORS = 32,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic [NUM_SENSORS-1:0] mask_i,
    input  logic [ADDR_W-1:0]      ptr_i,
    output logic [ADDR_W-1:0]      idx_o,
    output logic                   found_o
);

    int unsigned       cand;
    logic [ADDR_W-1:0] cand_idx;

    // Scan from the far end so the candidate closest to ptr_i is written last.
    always_comb begin
        idx_o    = '0;
        found_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
            cand     = (int'(ptr_i) + i) % NUM_SENSORS;
            cand_idx = ADDR_W'(cand);
            if (mask_i[cand_idx]) begin
                idx_o   = cand_idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_access_scheduler.sv
// Shares one DHT11 interface between one-shot reads and a round-robin background refresh,
// enforcing the inter-read gap, a read timeout and the checksum.
module sensor_access_scheduler
    import sensor_pkg::*;
#(
    parameter int unsigned NUM_SENSORS    = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned GAP_CYCLES     = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset_n,
    sensor_access_scheduler_if.slave bus_io
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GapW-1:0]   GapLoad  = GapW'(GAP_CYCLES);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_SENSORS - 1);

    sched_state_e           state_q;
    logic                   req_ready_q;
    logic                   sensor_start_q;
    logic [ADDR_W-1:0]      sensor_addr_q;
    logic [GapW-1:0]        gap_q;
    logic [TmoW-1:0]        tmo_q;
    logic [ADDR_W-1:0]      rr_ptr_q;
    logic                   rsp_valid_q;
    logic [ADDR_W-1:0]      rsp_addr_q;
    logic [DataW-1:0]       rsp_data_q;
    logic [1:0]             rsp_err_q;
    logic                   rsp_cont_q;
    logic [NUM_SENSORS-1:0] cont_mask_q, cont_mask_d;

    logic                   addr_ok;
    logic [ADDR_W-1:0]      pick_idx;
    logic                   pick_found;

    if (NUM_SENSORS >= (32'd1 << ADDR_W)) begin : g_full_range
        assign addr_ok = 1'b1;
    end else begin : g_part_range
        assign addr_ok = (32'(bus_io.cont_addr) < NUM_SENSORS);
    end

    // Clear is applied after set so it wins on a same-cycle collision.
    always_comb begin
        cont_mask_d = cont_mask_q;
        if (addr_ok && bus_io.cont_set) cont_mask_d[bus_io.cont_addr] = 1'b1;
        if (addr_ok && bus_io.cont_clr) cont_mask_d[bus_io.cont_addr] = 1'b0;
    end

    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            cont_mask_q <= '0;
        end else begin
            cont_mask_q <= cont_mask_d;
        end
    end

    rr_picker #(
        .NUM_SENSORS (NUM_SENSORS),
        .ADDR_W      (ADDR_W)
    ) u_rr_picker (
        .mask_i  (cont_mask_q),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            req_ready_q    <= 1'b0;
            sensor_start_q <= 1'b0;
            sensor_addr_q  <= '0;
            gap_q          <= '0;
            tmo_q          <= '0;
            rr_ptr_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_addr_q     <= '0;
            rsp_data_q     <= '0;
            rsp_err_q      <= RSP_OK;
            rsp_cont_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!req_ready_q) begin
                        req_ready_q <= 1'b1;
                    end else if (bus_io.req_valid) begin
                        sensor_addr_q  <= bus_io.req_addr;
                        rsp_cont_q     <= 1'b0;
                        req_ready_q    <= 1'b0;
                        sensor_start_q <= 1'b1;
                        state_q        <= StStart;
                    end else if (pick_found) begin
                        sensor_addr_q  <= pick_idx;
                        rsp_cont_q     <= 1'b1;
                        req_ready_q    <= 1'b0;
                        sensor_start_q <= 1'b1;
                        state_q        <= StStart;
                    end
                end
                StStart: begin
                    sensor_start_q <= 1'b0;
                    tmo_q          <= '0;
                    state_q        <= StWait;
                end
                StWait: begin
                    if (bus_io.sensor_done) begin
                        rsp_data_q  <= bus_io.data_sensor;
                        rsp_err_q   <= cksum_ok(bus_io.data_sensor) ? RSP_OK : RSP_CKSUM;
                        rsp_addr_q  <= sensor_addr_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (tmo_q == TmoLast) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= RSP_TIMEOUT;
                        rsp_addr_q  <= sensor_addr_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StResp: begin
                    if (bus_io.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        gap_q       <= GapLoad;
                        if (rsp_cont_q) begin
                            rr_ptr_q <= (sensor_addr_q == LastAddr) ? '0 : sensor_addr_q + 1'b1;
                        end
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (gap_q == '0) begin
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.req_ready    = req_ready_q;
    assign bus_io.cont_mask    = cont_mask_q;
    assign bus_io.sensor_start = sensor_start_q;
    assign bus_io.sensor_addr  = sensor_addr_q;
    assign bus_io.rsp_valid    = rsp_valid_q;
    assign bus_io.rsp_addr     = rsp_addr_q;
    assign bus_io.rsp_data     = rsp_data_q;
    assign bus_io.rsp_err      = rsp_err_q;
    assign bus_io.rsp_cont     = rsp_cont_q;

endmodule

// File: tb/tb_sensor_access_scheduler.sv
// Bench for sensor_access_scheduler: directed table, hand-written corner sequences and a
// randomized run scored against a queue-free behavioural model of the scheduling rules.
module tb_sensor_access_scheduler;

    localparam int unsigned Gap = 20;
    localparam int unsigned Tmo = 50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sensor_access_scheduler_if #(.NUM_SENSORS(32), .ADDR_W(5)) bus ();

    sensor_access_scheduler #(
        .NUM_SENSORS    (32),
        .ADDR_W         (5),
        .GAP_CYCLES     (Gap),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clock_50Mhz (clk),
        .reset_n     (rst_n),
        .bus_io      (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          starts = 0;
    int          last_hs = 0;
    bit          hs_valid = 1'b0;
    bit          prev_start = 1'b0;
    logic [31:0] m_mask = '0;
    int          m_ptr = 0;

    typedef struct {
        logic [4:0]  addr;
        bit          give_done;
        int          delay;
        logic [39:0] data;
        int          stall;
        logic [1:0]  exp_err;
        logic [39:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_sum(input logic [39:0] d);
        return d[39:32] + d[31:24] + d[23:16] + d[15:8];
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < 32; k++) begin
            if (m_mask[(m_ptr + k) % 32]) return (m_ptr + k) % 32;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    // Pulse width and inter-read gap, observed independently of the transaction driver.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (bus.sensor_start) begin
                starts++;
                check("start_one_cycle", {63'd0, prev_start}, 64'd0);
                if (hs_valid) check("gap_after_handshake", {63'd0, (cyc - last_hs) >= Gap}, 64'd1);
            end
            prev_start = bus.sensor_start;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, " req_ready"}, bus.req_ready, 0);
        check({tag, " sensor_start"}, bus.sensor_start, 0);
        check({tag, " sensor_addr"}, bus.sensor_addr, 0);
        check({tag, " rsp_valid"}, bus.rsp_valid, 0);
        check({tag, " rsp_addr"}, bus.rsp_addr, 0);
        check({tag, " rsp_data"}, bus.rsp_data, 0);
        check({tag, " rsp_err"}, bus.rsp_err, 0);
        check({tag, " rsp_cont"}, bus.rsp_cont, 0);
        check({tag, " cont_mask"}, bus.cont_mask, 0);
    endtask

    // One complete read: issue or await the start, apply mask edits, answer (or not), consume.
    task automatic do_txn(input string tag, input bit oneshot, input logic [4:0] oaddr,
                          input logic [31:0] set_bits, input logic [31:0] clr_bits,
                          input bit give_done, input int delay, input logic [39:0] data,
                          input int stall_in, input logic [4:0] exp_addr, input bit exp_cont,
                          input logic [1:0] exp_err, input logic [39:0] exp_data);
        int s0;
        bit got;
        int ops;
        int stall;
        s0  = starts;
        got = 1'b0;
        if (oneshot) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = oaddr;
            for (int k = 0; k < 200 && !got; k++) begin
                if (bus.req_ready) got = 1'b1;
                @(negedge clk);
            end
            bus.req_valid = 1'b0;
            check({tag, " req_accepted"}, {63'd0, got}, 1);
            check({tag, " start_latency"}, bus.sensor_start, 1);
        end else begin
            for (int k = 0; k < 200 && !got; k++) begin
                if (bus.sensor_start) got = 1'b1;
                else @(negedge clk);
            end
            check({tag, " start_seen"}, {63'd0, got}, 1);
        end
        check({tag, " sensor_addr"}, bus.sensor_addr, exp_addr);

        ops = 0;
        for (int a = 0; a < 32; a++) begin
            if ((set_bits[a] || clr_bits[a]) && ops < 12) begin
                bus.cont_addr = a[4:0];
                bus.cont_set  = set_bits[a];
                bus.cont_clr  = clr_bits[a];
                @(negedge clk);
                ops++;
                if (set_bits[a]) m_mask[a] = 1'b1;
                if (clr_bits[a]) m_mask[a] = 1'b0;
            end
        end
        bus.cont_set = 1'b0;
        bus.cont_clr = 1'b0;

        if (give_done) begin
            repeat (delay) @(negedge clk);
            bus.data_sensor = data;
            bus.sensor_done = 1'b1;
            @(negedge clk);
            bus.sensor_done = 1'b0;
        end

        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (bus.rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, " rsp_seen"}, {63'd0, got}, 1);
        check({tag, " rsp_addr"}, bus.rsp_addr, exp_addr);
        check({tag, " rsp_data"}, bus.rsp_data, exp_data);
        check({tag, " rsp_err"}, bus.rsp_err, exp_err);
        check({tag, " rsp_cont"}, bus.rsp_cont, exp_cont);
        check({tag, " cont_mask"}, bus.cont_mask, m_mask);

        stall = (!give_done && stall_in < 8) ? 8 : stall_in;
        for (int k = 0; k < stall; k++) begin
            if (!give_done && k == 5) begin
                bus.data_sensor = 40'h2A_00_19_00_43;
                bus.sensor_done = 1'b1;
            end
            @(negedge clk);
            bus.sensor_done = 1'b0;
        end
        if (stall > 0) begin
            check({tag, " held_valid"}, bus.rsp_valid, 1);
            check({tag, " held_addr"}, bus.rsp_addr, exp_addr);
            check({tag, " held_data"}, bus.rsp_data, exp_data);
            check({tag, " held_err"}, bus.rsp_err, exp_err);
        end

        bus.rsp_ready = 1'b1;
        last_hs  = cyc;
        hs_valid = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, " rsp_dropped"}, bus.rsp_valid, 0);
        check({tag, " one_start"}, 64'(starts - s0), 1);
        if (exp_cont) m_ptr = (int'(exp_addr) + 1) % 32;
    endtask

    initial begin
        int rr_exp[4];
        bit got;

        vecs[0] = '{5'd3,  1'b1, 4,  40'h2A_00_19_00_43, 0, 2'b00, 40'h2A_00_19_00_43};
        vecs[1] = '{5'd9,  1'b1, 7,  40'h2A_00_19_00_44, 2, 2'b01, 40'h2A_00_19_00_44};
        vecs[2] = '{5'd12, 1'b0, 0,  40'h0,              3, 2'b10, 40'h0};
        vecs[3] = '{5'd31, 1'b1, 1,  40'hFF_FF_00_00_FE, 0, 2'b00, 40'hFF_FF_00_00_FE};
        vecs[4] = '{5'd0,  1'b1, 30, 40'h00_00_00_00_00, 1, 2'b00, 40'h00_00_00_00_00};
        vecs[5] = '{5'd17, 1'b1, 12, 40'h01_02_03_04_0A, 3, 2'b00, 40'h01_02_03_04_0A};
        rr_exp  = '{2, 5, 31, 2};

        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.cont_set    = 1'b0;
        bus.cont_clr    = 1'b0;
        bus.cont_addr   = '0;
        bus.sensor_done = 1'b0;
        bus.data_sensor = '0;
        bus.rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", bus.req_ready, 1);

        foreach (vecs[i]) begin
            do_txn($sformatf("vec%0d", i), 1'b1, vecs[i].addr, 32'h0, 32'h0, vecs[i].give_done,
                   vecs[i].delay, vecs[i].data, vecs[i].stall, vecs[i].addr, 1'b0,
                   vecs[i].exp_err, vecs[i].exp_data);
        end

        // Enable 2, 5, 31 while a one-shot is in flight, then watch the rotation.
        do_txn("rr_setup", 1'b1, 5'd8, 32'h8000_0024, 32'h0, 1'b1, 3, 40'h01_02_03_04_0A, 0,
               5'd8, 1'b0, 2'b00, 40'h01_02_03_04_0A);
        foreach (rr_exp[i]) begin
            do_txn($sformatf("rr%0d", i), 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 2,
                   40'h10_20_30_40_A0, 1, 5'(rr_exp[i]), 1'b1, 2'b00, 40'h10_20_30_40_A0);
        end

        // One-shot raised during HOLD beats the pending continuous refresh.
        do_txn("prio", 1'b1, 5'd7, 32'h0, 32'h0, 1'b1, 5, 40'h2A_00_19_00_43, 0,
               5'd7, 1'b0, 2'b00, 40'h2A_00_19_00_43);
        do_txn("prio_next", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5, 40'h2A_00_19_00_00, 0,
               5'd5, 1'b1, 2'b01, 40'h2A_00_19_00_00);

        // Reset in WAIT, then a colliding set/clear on address 4.
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd10;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (bus.req_ready) got = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("rst_req_accepted", {63'd0, got}, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_wait_reset");
        rst_n         = 1'b1;
        m_mask        = '0;
        m_ptr         = 0;
        hs_valid      = 1'b0;
        bus.cont_addr = 5'd4;
        bus.cont_set  = 1'b1;
        bus.cont_clr  = 1'b1;
        @(negedge clk);
        bus.cont_set = 1'b0;
        bus.cont_clr = 1'b0;
        check("set_clr_collision_mask", bus.cont_mask, 0);
        repeat (8) @(negedge clk);
        check("no_rsp_after_abort", bus.rsp_valid, 0);

        for (int t = 0; t < 30; t++) begin
            logic [31:0] sb, cb;
            logic [39:0] d, ed;
            logic [1:0]  ee;
            logic [4:0]  oa;
            bit          os, gd;
            int          pa;
            os = ($urandom_range(0, 3) == 0) || (m_mask == 0);
            oa = 5'($urandom_range(0, 31));
            sb = $urandom & $urandom & $urandom;
            cb = $urandom & $urandom & $urandom;
            gd = ($urandom_range(0, 5) != 0);
            d[39:8] = $urandom;
            d[7:0]  = ref_sum(d);
            if ($urandom_range(0, 1) == 1) d[7:0] = d[7:0] ^ 8'($urandom_range(1, 255));
            pa = os ? int'(oa) : model_pick();
            ee = !gd ? 2'b10 : (ref_sum(d) == d[7:0]) ? 2'b00 : 2'b01;
            ed = gd ? d : 40'h0;
            do_txn($sformatf("rand%0d", t), os, oa, sb, cb, gd, $urandom_range(1, 20), d,
                   $urandom_range(0, 4), 5'(pa), !os, ee, ed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
